// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Stage records store addresses at REC_AW bits, so register-address widths up to 8 fit.
package pipe_hazard_ctrl_pkg;

    localparam int DEFAULT_AW = 5;
    localparam int REC_AW     = 8;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic              valid;
        logic [REC_AW-1:0] rs;
        logic [REC_AW-1:0] rt;
        logic              rsUsed;
        logic              rtUsed;
        logic [REC_AW-1:0] dst;
        logic              regwrite;
        logic              memread;
    } stageRecT;

    // True when stage s will write register r and the reader actually uses r.
    function automatic logic writerMatch(stageRecT s, logic used, logic [REC_AW-1:0] r);
        return s.valid && s.regwrite && (s.dst != '0) && used && (r == s.dst);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use/interlock stalls, branch flushes,
// EX operand forwarding selects and saturating stall/flush counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int AW     = DEFAULT_AW,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs,
    input  logic [AW-1:0]    id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [AW-1:0]    id_dst,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             ex_br_taken,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             bubble_idex,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    stageRecT idRec, exRec, memRec, wbRec;
    logic     rawEx, rawMem, rawWb, stallReq, stallNow, flushNow;

    function automatic logic [1:0] fwdSel(logic used, logic [REC_AW-1:0] r);
        if (writerMatch(memRec, used, r))
            return FWD_MEM;
        else if (writerMatch(wbRec, used, r))
            return FWD_WB;
        return FWD_RF;
    endfunction

    always_comb begin
        idRec          = '0;
        idRec.valid    = id_valid;
        idRec.rs       = REC_AW'(id_rs);
        idRec.rt       = REC_AW'(id_rt);
        idRec.rsUsed   = id_rs_used;
        idRec.rtUsed   = id_rt_used;
        idRec.dst      = REC_AW'(id_dst);
        idRec.regwrite = id_regwrite;
        idRec.memread  = id_memread;
    end

    // NOTE: every variable in this block gets a value on every path, so no latch is inferred.
    always_comb begin
        rawEx  = writerMatch(exRec,  idRec.rsUsed, idRec.rs) || writerMatch(exRec,  idRec.rtUsed, idRec.rt);
        rawMem = writerMatch(memRec, idRec.rsUsed, idRec.rs) || writerMatch(memRec, idRec.rtUsed, idRec.rt);
        rawWb  = writerMatch(wbRec,  idRec.rsUsed, idRec.rs) || writerMatch(wbRec,  idRec.rtUsed, idRec.rt);
        if (FWD_EN != 0)
            stallReq = id_valid && rawEx && exRec.memread;
        else
            stallReq = id_valid && (rawEx || rawMem || rawWb);
        flushNow = ex_br_taken && !rst;
        stallNow = stallReq && !flushNow && !rst;
        fwd_a    = FWD_RF;
        fwd_b    = FWD_RF;
        // An empty EX slot has no operands to feed.
        if ((FWD_EN != 0) && !rst && exRec.valid) begin
            fwd_a = fwdSel(exRec.rsUsed, exRec.rs);
            fwd_b = fwdSel(exRec.rtUsed, exRec.rt);
        end
    end

    assign stall_pc    = stallNow;
    assign stall_ifid  = stallNow;
    assign bubble_idex = stallNow;
    assign flush_ifid  = flushNow;
    assign flush_idex  = flushNow;

    always_ff @(posedge clk) begin
        if (rst) begin
            exRec  <= '0;
            memRec <= '0;
            wbRec  <= '0;
        end else begin
            exRec  <= (stallNow || flushNow) ? '0 : idRec;
            memRec <= exRec;
            wbRec  <= memRec;
        end
    end

    // Source fields of the older stages are carried for completeness but never compared.
    logic unusedRecBits;
    assign unusedRecBits = ^{memRec.rs, memRec.rt, memRec.rsUsed, memRec.rtUsed, memRec.memread,
                             wbRec.rs, wbRec.rt, wbRec.rsUsed, wbRec.rtUsed, wbRec.memread};

    sat_counter #(.CNT_W(CNT_W)) stallCounter (
        .clk   (clk),
        .rst   (rst),
        .inc   (stallNow),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) flushCounter (
        .clk   (clk),
        .rst   (rst),
        .inc   (flushNow),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a forwarding instance (CNT_W=4) and an interlock instance
// share one input stream; a history-queue model, a vector table and hand sequences check them.
module tb_pipe_hazard_ctrl;

    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst;
    logic id_valid, id_rs_used, id_rt_used, id_regwrite, id_memread, ex_br_taken;
    logic [AW-1:0] id_rs, id_rt, id_dst;

    logic fStallPc, fStallIfid, fBubble, fFlushIfid, fFlushIdex;
    logic [1:0] fFwdA, fFwdB;
    logic [3:0] fStallCnt, fFlushCnt;
    logic lStallPc, lStallIfid, lBubble, lFlushIfid, lFlushIdex;
    logic [1:0] lFwdA, lFwdB;
    logic [15:0] lStallCnt, lFlushCnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.AW(AW), .FWD_EN(1), .CNT_W(4)) dutFwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_dst(id_dst),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_br_taken(ex_br_taken),
        .stall_pc(fStallPc), .stall_ifid(fStallIfid), .bubble_idex(fBubble),
        .flush_ifid(fFlushIfid), .flush_idex(fFlushIdex), .fwd_a(fFwdA), .fwd_b(fFwdB),
        .stall_cnt(fStallCnt), .flush_cnt(fFlushCnt)
    );

    pipe_hazard_ctrl #(.AW(AW), .FWD_EN(0), .CNT_W(16)) dutLock (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_dst(id_dst),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_br_taken(ex_br_taken),
        .stall_pc(lStallPc), .stall_ifid(lStallIfid), .bubble_idex(lBubble),
        .flush_ifid(lFlushIfid), .flush_idex(lFlushIdex), .fwd_a(lFwdA), .fwd_b(lFwdB),
        .stall_cnt(lStallCnt), .flush_cnt(lFlushCnt)
    );

    typedef struct {
        bit v;
        int rs, rt;
        bit ru, tu;
        int dst;
        bit rw, mr;
    } instr_t;

    typedef struct {
        instr_t in;
        bit     br;
        bit     expStall, expFlush;
        int     expFwdA, expFwdB;
    } vec_t;

    int tests = 0;
    int fails = 0;

    // Model: per instance, a history of what entered EX on each of the last three edges.
    instr_t pipeF[$], pipeL[$];
    int     stallCntF, flushCntF, stallCntL, flushCntL;
    instr_t cur;
    bit     curBr, curRst;
    bit     expSF, expSL, expFl;
    instr_t nop;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic instr_t mk(bit v, int rs, int rt, bit ru, bit tu, int dst, bit rw, bit mr);
        instr_t i;
        i.v = v; i.rs = rs; i.rt = rt; i.ru = ru; i.tu = tu; i.dst = dst; i.rw = rw; i.mr = mr;
        return i;
    endfunction

    function automatic bit writes(instr_t s, bit used, int r);
        return s.v && s.rw && (s.dst != 0) && used && (r == s.dst);
    endfunction

    function automatic bit readsFrom(instr_t s, instr_t reader);
        return writes(s, reader.ru, reader.rs) || writes(s, reader.tu, reader.rt);
    endfunction

    function automatic int fwdFor(instr_t ex, instr_t mem, instr_t wb, bit used, int r);
        if (!ex.v) return 0;
        if (writes(mem, used, r)) return 2;
        if (writes(wb, used, r)) return 1;
        return 0;
    endfunction

    task automatic modelReset();
        pipeF = '{nop, nop, nop};
        pipeL = '{nop, nop, nop};
        stallCntF = 0; flushCntF = 0; stallCntL = 0; flushCntL = 0;
    endtask

    task automatic apply(input instr_t i, input bit br, input bit r);
        cur = i; curBr = br; curRst = r;
        rst = r; ex_br_taken = br;
        id_valid = i.v; id_rs = AW'(i.rs); id_rt = AW'(i.rt);
        id_rs_used = i.ru; id_rt_used = i.tu; id_dst = AW'(i.dst);
        id_regwrite = i.rw; id_memread = i.mr;
    endtask

    task automatic modelCheck();
        bit hazL;
        int fa, fb;
        hazL = 1'b0;
        for (int k = 0; k < 3; k++) hazL |= readsFrom(pipeL[k], cur);
        expFl = curBr && !curRst;
        expSF = cur.v && pipeF[0].mr && readsFrom(pipeF[0], cur) && !expFl && !curRst;
        expSL = cur.v && hazL && !expFl && !curRst;
        fa = curRst ? 0 : fwdFor(pipeF[0], pipeF[1], pipeF[2], pipeF[0].ru, pipeF[0].rs);
        fb = curRst ? 0 : fwdFor(pipeF[0], pipeF[1], pipeF[2], pipeF[0].tu, pipeF[0].rt);
        check("fwd.stall", int'({fStallPc, fStallIfid, fBubble}), expSF ? 7 : 0);
        check("fwd.flush", int'({fFlushIfid, fFlushIdex}), expFl ? 3 : 0);
        check("fwd.fwd_a", int'(fFwdA), fa);
        check("fwd.fwd_b", int'(fFwdB), fb);
        check("fwd.stall_cnt", int'(fStallCnt), stallCntF);
        check("fwd.flush_cnt", int'(fFlushCnt), flushCntF);
        check("lock.stall", int'({lStallPc, lStallIfid, lBubble}), expSL ? 7 : 0);
        check("lock.flush", int'({lFlushIfid, lFlushIdex}), expFl ? 3 : 0);
        check("lock.fwd", int'({lFwdA, lFwdB}), 0);
        check("lock.stall_cnt", int'(lStallCnt), stallCntL);
        check("lock.flush_cnt", int'(lFlushCnt), flushCntL);
    endtask

    task automatic modelAdvance();
        if (curRst) begin
            modelReset();
        end else begin
            pipeF.push_front((expSF || expFl) ? nop : cur);
            void'(pipeF.pop_back());
            pipeL.push_front((expSL || expFl) ? nop : cur);
            void'(pipeL.pop_back());
            if (expSF) stallCntF = (stallCntF < 15) ? stallCntF + 1 : 15;
            if (expSL) stallCntL = (stallCntL < 65535) ? stallCntL + 1 : 65535;
            if (expFl) begin
                flushCntF = (flushCntF < 15) ? flushCntF + 1 : 15;
                flushCntL = (flushCntL < 65535) ? flushCntL + 1 : 65535;
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        modelCheck();
    endtask

    task automatic advance();
        @(posedge clk);
        modelAdvance();
        #1;
    endtask

    task automatic cycle(input instr_t i, input bit br, input bit r);
        apply(i, br, r);
        settle();
        advance();
    endtask

    task automatic doReset();
        apply(nop, 1'b0, 1'b1);
        @(posedge clk);
        modelReset();
        #1;
        cycle(nop, 1'b0, 1'b1);
    endtask

    vec_t   tbl[18];
    instr_t lw4, dep4, add5, or5;
    bit     lockExp[4];
    int     fwdExp[4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0);
        //              instruction                      br  stall flush fa fb
        tbl[0]  = '{mk(1, 1, 2, 1, 1,  3, 1, 0), 1'b0, 1'b0, 1'b0, 0, 0}; // add $3
        tbl[1]  = '{mk(1, 3, 9, 1, 1,  8, 1, 0), 1'b0, 1'b0, 1'b0, 0, 0}; // sub uses $3
        tbl[2]  = '{nop,                         1'b0, 1'b0, 1'b0, 2, 0}; // sub in EX: fwd_a=MEM
        tbl[3]  = '{mk(1, 1, 0, 1, 0,  4, 1, 1), 1'b0, 1'b0, 1'b0, 0, 0}; // lw $4
        tbl[4]  = '{mk(1, 2, 4, 1, 1, 10, 1, 0), 1'b0, 1'b1, 1'b0, 0, 0}; // load-use stall
        tbl[5]  = '{mk(1, 2, 4, 1, 1, 10, 1, 0), 1'b0, 1'b0, 1'b0, 0, 0}; // held, no stall
        tbl[6]  = '{nop,                         1'b0, 1'b0, 1'b0, 0, 1}; // fwd_b=WB
        tbl[7]  = '{mk(1, 1, 0, 1, 0,  6, 1, 1), 1'b0, 1'b0, 1'b0, 0, 0}; // lw $6
        tbl[8]  = '{mk(1, 6, 0, 1, 1, 11, 1, 0), 1'b1, 1'b0, 1'b1, 0, 0}; // dependent + branch
        tbl[9]  = '{mk(1, 6, 0, 1, 1, 11, 1, 0), 1'b0, 1'b0, 1'b0, 0, 0}; // EX empty, no stall
        tbl[10] = '{mk(1, 1, 2, 1, 1,  0, 1, 0), 1'b0, 1'b0, 1'b0, 1, 0}; // add $0; EX reads lw $6 from WB
        tbl[11] = '{mk(1, 1, 0, 1, 0,  0, 1, 1), 1'b0, 1'b0, 1'b0, 0, 0}; // lw $0
        tbl[12] = '{mk(1, 0, 0, 1, 1, 12, 1, 0), 1'b0, 1'b0, 1'b0, 0, 0}; // reads $0 after lw $0
        tbl[13] = '{mk(1, 1, 2, 1, 1,  7, 1, 0), 1'b0, 1'b0, 1'b0, 0, 0}; // add $7
        tbl[14] = '{mk(1, 1, 2, 1, 1,  7, 1, 0), 1'b0, 1'b0, 1'b0, 0, 0}; // add $7 again
        tbl[15] = '{mk(1, 7, 7, 1, 1, 13, 1, 0), 1'b0, 1'b0, 1'b0, 0, 0}; // sub uses $7, $7
        tbl[16] = '{nop,                         1'b0, 1'b0, 1'b0, 2, 2}; // MEM beats WB
        tbl[17] = '{nop,                         1'b0, 1'b0, 1'b0, 0, 0};

        doReset();
        for (int k = 0; k < 18; k++) begin
            apply(tbl[k].in, tbl[k].br, 1'b0);
            settle();
            check($sformatf("vec%0d", k), int'({fStallPc, fFlushIfid, fFwdA, fFwdB}),
                  int'({tbl[k].expStall, tbl[k].expFlush, 2'(tbl[k].expFwdA), 2'(tbl[k].expFwdB)}));
            advance();
        end
        check("table.stall_cnt", int'(fStallCnt), 1);
        check("table.flush_cnt", int'(fFlushCnt), 1);

        // Interlock: dependent 'or' held in ID behind 'add $5'.
        doReset();
        add5 = mk(1, 1, 2, 1, 1, 5, 1, 0);
        or5  = mk(1, 5, 3, 1, 1, 14, 1, 0);
        lockExp = '{1'b1, 1'b1, 1'b1, 1'b0};
        fwdExp  = '{0, 2, 1, 0};
        cycle(add5, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            apply(or5, 1'b0, 1'b0);
            settle();
            check($sformatf("lock.seq%0d.stall", k), int'(lStallPc), int'(lockExp[k]));
            check($sformatf("lock.seq%0d.fwd", k), int'({lFwdA, lFwdB}), 0);
            check($sformatf("fwd.seq%0d.stall", k), int'(fStallPc), 0);
            check($sformatf("fwd.seq%0d.fwd_a", k), int'(fFwdA), fwdExp[k]);
            advance();
        end
        check("lock.seq.stall_cnt", int'(lStallCnt), 3);
        check("fwd.seq.stall_cnt", int'(fStallCnt), 0);

        // Flush counter saturation.
        doReset();
        for (int k = 0; k < 20; k++) cycle(nop, 1'b1, 1'b0);
        check("sat.fwd.flush_cnt", int'(fFlushCnt), 15);
        check("sat.lock.flush_cnt", int'(lFlushCnt), 20);

        // Reset during an ongoing interlock stall, with a branch pending as well.
        doReset();
        lw4  = mk(1, 1, 0, 1, 0, 4, 1, 1);
        dep4 = mk(1, 2, 4, 1, 1, 10, 1, 0);
        cycle(lw4, 1'b0, 1'b0);
        apply(dep4, 1'b0, 1'b0);
        settle();
        check("rstmid.pre.fwd_stall", int'(fStallPc), 1);
        check("rstmid.pre.lock_stall", int'(lStallPc), 1);
        advance();
        apply(dep4, 1'b1, 1'b1);
        settle();
        check("rstmid.fwd_outs", int'({fStallPc, fStallIfid, fBubble, fFlushIfid, fFlushIdex, fFwdA, fFwdB}), 0);
        check("rstmid.lock_outs", int'({lStallPc, lStallIfid, lBubble, lFlushIfid, lFlushIdex, lFwdA, lFwdB}), 0);
        advance();
        apply(dep4, 1'b0, 1'b0);
        settle();
        check("rstmid.cnts", int'({fStallCnt, lStallCnt}), 0);
        check("rstmid.after.stall", int'({fStallPc, lStallPc}), 0);
        advance();

        // Randomized traffic against the model.
        doReset();
        for (int k = 0; k < 600; k++) begin
            instr_t r;
            r = mk($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            cycle(r, $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
